// File: rtl/hsv_mask_receiver.sv
// Serial HSV receiver: synchronises the Pi bit stream into fpga_clk, classifies each pixel as hand/not-hand and stores the binary mask.
// Pixel write lands 2-3 cycles after the last pi_clk rise; no backpressure, pixels past a full frame are counted and dropped.
module hsv_mask_receiver #(
  parameter int LENGTH         = 28,
  parameter int WIDTH          = 28,
  parameter int CH_W           = 8,
  parameter int MIN_HUE        = 0,
  parameter int MAX_HUE        = 25,
  parameter int MIN_SATURATION = 40,
  parameter int MIN_VALUE      = 60,
  localparam int RW            = $clog2(LENGTH),
  localparam int CW            = $clog2(WIDTH),
  localparam int PC_W          = $clog2(LENGTH*WIDTH+1)
) (
  input  logic            fpga_clk,
  input  logic            rst,
  input  logic            pi_clk,
  input  logic            data_in,
  input  logic            write_enable,
  input  logic            clear,
  input  logic [RW-1:0]   rd_row,
  input  logic [CW-1:0]   rd_col,
  output logic            rd_bit,
  output logic            frame_ready,
  output logic [PC_W-1:0] pixel_count,
  output logic [7:0]      drop_count
);
  localparam int PIX_BITS = 3*CH_W;
  localparam int BC_W     = $clog2(PIX_BITS);
  localparam int CH_X     = CH_W + 1;

  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PIX_BITS-1);
  localparam logic [PC_W-1:0] LAST_PIX = PC_W'(LENGTH*WIDTH-1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(LENGTH-1);
  localparam logic [CW-1:0]   LAST_COL = CW'(WIDTH-1);
  localparam logic [CH_X-1:0] ONE      = CH_X'(1);
  localparam logic [CH_X-1:0] MIN_H    = CH_X'(MIN_HUE);
  localparam logic [CH_X-1:0] MAX_H1   = CH_X'(MAX_HUE+1);
  localparam logic [CH_X-1:0] MIN_S    = CH_X'(MIN_SATURATION);
  localparam logic [CH_X-1:0] MIN_V    = CH_X'(MIN_VALUE);
  localparam bit              HUE_WRAP = (MIN_HUE > MAX_HUE);

  logic                pi_s1, pi_s2, pi_s3;
  logic                data_s1, data_s2;
  logic                we_s1, we_s2, we_s3;
  logic                strobe, we_fall;
  logic [BC_W-1:0]     bit_cnt;
  logic [PIX_BITS-2:0] pix_buf;
  logic [PIX_BITS-1:0] pix;
  logic [CH_X-1:0]     hue_x, sat_x, val_x;
  logic                hue_ge, hue_le, hue_ok, hand;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;
  logic [WIDTH-1:0]    mask [LENGTH];

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      {pi_s1, pi_s2, pi_s3}    <= 3'b000;
      {data_s1, data_s2}       <= 2'b00;
      {we_s1, we_s2, we_s3}    <= 3'b000;
    end else begin
      {pi_s1, pi_s2, pi_s3}    <= {pi_clk, pi_s1, pi_s2};
      {data_s1, data_s2}       <= {data_in, data_s1};
      {we_s1, we_s2, we_s3}    <= {write_enable, we_s1, we_s2};
    end
  end

  assign strobe  = pi_s2 & ~pi_s3;
  assign we_fall = ~we_s2 & we_s3;

  // Last bit joins the buffered bits combinationally so the pixel is classified on its final strobe.
  assign pix   = {data_s2, pix_buf};
  assign hue_x = {1'b0, pix[CH_W-1:0]};
  assign sat_x = {1'b0, pix[2*CH_W-1:CH_W]};
  assign val_x = {1'b0, pix[3*CH_W-1:2*CH_W]};

  // Inclusive bounds written as x+1 > lo and x < hi+1 in one extra bit, so zero/full-scale bounds stay well-formed.
  assign hue_ge = (hue_x + ONE) > MIN_H;
  assign hue_le = hue_x < MAX_H1;
  assign hue_ok = HUE_WRAP ? (hue_ge | hue_le) : (hue_ge & hue_le);
  assign hand   = hue_ok & ((sat_x + ONE) > MIN_S) & ((val_x + ONE) > MIN_V);

  always_ff @(posedge fpga_clk) begin
    if (rst || clear) begin
      bit_cnt     <= '0;
      pix_buf     <= '0;
      row         <= '0;
      col         <= '0;
      pixel_count <= '0;
      drop_count  <= '0;
      frame_ready <= 1'b0;
      rd_bit      <= 1'b0;
      for (int r = 0; r < LENGTH; r++) mask[r] <= '0;
    end else begin
      rd_bit <= (rd_row <= LAST_ROW && rd_col <= LAST_COL) ? mask[rd_row][rd_col] : 1'b0;
      if (we_fall) begin
        bit_cnt <= '0;
        pix_buf <= '0;
      end else if (strobe && we_s2) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          pix_buf <= '0;
          if (frame_ready) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          end else begin
            mask[row][col] <= hand;
            pixel_count    <= pixel_count + 1'b1;
            if (pixel_count == LAST_PIX) frame_ready <= 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end else begin
          pix_buf[bit_cnt] <= data_s2;
          bit_cnt          <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_mask_receiver.sv
// Bench for hsv_mask_receiver: a default-threshold instance and a wrapped-hue instance share one serial stream, checked against a frame model.
module tb_hsv_mask_receiver;
  localparam int L    = 28;
  localparam int W    = 28;
  localparam int NPIX = L*W;

  logic       fpga_clk = 1'b0;
  logic       rst = 1'b1;
  logic       pi_clk = 1'b0;
  logic       data_in = 1'b0;
  logic       write_enable = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic       rd_bit_a, rd_bit_b, ready_a, ready_b;
  logic [9:0] cnt_a, cnt_b;
  logic [7:0] drop_a, drop_b;

  hsv_mask_receiver dut_a (
    .fpga_clk(fpga_clk), .rst(rst), .pi_clk(pi_clk), .data_in(data_in),
    .write_enable(write_enable), .clear(clear), .rd_row(rd_row), .rd_col(rd_col),
    .rd_bit(rd_bit_a), .frame_ready(ready_a), .pixel_count(cnt_a), .drop_count(drop_a)
  );

  hsv_mask_receiver #(.MIN_HUE(240), .MAX_HUE(20)) dut_b (
    .fpga_clk(fpga_clk), .rst(rst), .pi_clk(pi_clk), .data_in(data_in),
    .write_enable(write_enable), .clear(clear), .rd_row(rd_row), .rd_col(rd_col),
    .rd_bit(rd_bit_b), .frame_ready(ready_b), .pixel_count(cnt_b), .drop_count(drop_b)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_chk = 0;
  int n_err = 0;
  int hp    = 1;
  bit exp_a [NPIX];
  bit exp_b [NPIX];
  int exp_cnt  = 0;
  int exp_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hand(input logic [23:0] p, input int mn, input int mx);
    int h, s, v;
    bit hok;
    h = int'(p[7:0]);
    s = int'(p[15:8]);
    v = int'(p[23:16]);
    if (mn <= mx) hok = (h >= mn) && (h <= mx);
    else          hok = (h >= mn) || (h <= mx);
    return hok && (s >= 40) && (v >= 60);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) begin
      exp_a[i] = 1'b0;
      exp_b[i] = 1'b0;
    end
    exp_cnt  = 0;
    exp_drop = 0;
  endtask

  task automatic model_pixel(input logic [23:0] p);
    if (exp_cnt < NPIX) begin
      exp_a[exp_cnt] = is_hand(p, 0, 25);
      exp_b[exp_cnt] = is_hand(p, 240, 20);
      exp_cnt++;
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  function automatic logic [7:0] pick_ch(input int ch);
    int k;
    k = int'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 255));
    case (ch)
      0:       return (k == 0) ? 8'd25 : (k == 1) ? 8'd26 : (k == 2) ? 8'd240 : 8'd20;
      1:       return (k < 2) ? 8'd39 : 8'd40;
      default: return (k < 2) ? 8'd59 : 8'd60;
    endcase
  endfunction

  function automatic logic [23:0] rand_pix();
    return {pick_ch(2), pick_ch(1), pick_ch(0)};
  endfunction

  task automatic send_bit(input logic b);
    data_in = b;
    pi_clk  = 1'b1;
    repeat (hp) @(negedge fpga_clk);
    pi_clk  = 1'b0;
    repeat (hp) @(negedge fpga_clk);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    write_enable = 1'b1;
    for (int i = 0; i < 24; i++) send_bit(p[i]);
    repeat (3) @(negedge fpga_clk);
    model_pixel(p);
  endtask

  task automatic send_partial(input int n);
    write_enable = 1'b1;
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    write_enable = 1'b0;
    repeat (4) @(negedge fpga_clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge fpga_clk);
    rst = 1'b0;
    model_reset();
    @(negedge fpga_clk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_cnt_a"},   32'(cnt_a),   32'(exp_cnt));
    chk({tag, "_cnt_b"},   32'(cnt_b),   32'(exp_cnt));
    chk({tag, "_rdy_a"},   32'(ready_a), 32'(exp_cnt == NPIX));
    chk({tag, "_rdy_b"},   32'(ready_b), 32'(exp_cnt == NPIX));
    chk({tag, "_drop_a"},  32'(drop_a),  32'(exp_drop));
    chk({tag, "_drop_b"},  32'(drop_b),  32'(exp_drop));
  endtask

  task automatic rd_chk(input int r, input int c, input string tag);
    bit ea, eb;
    rd_row = 5'(r);
    rd_col = 5'(c);
    @(negedge fpga_clk);
    ea = (r < L && c < W) ? exp_a[r*W+c] : 1'b0;
    eb = (r < L && c < W) ? exp_b[r*W+c] : 1'b0;
    chk({tag, "_rd_a"}, 32'(rd_bit_a), 32'(ea));
    chk({tag, "_rd_b"}, 32'(rd_bit_b), 32'(eb));
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < NPIX; i++) rd_chk(i / W, i % W, tag);
  endtask

  initial begin
    do_reset();
    check_status("reset");
    rd_chk(0, 0, "reset");

    send_pixel(24'h50_64_0A);
    check_status("basic");
    rd_chk(0, 0, "basic");

    send_pixel(24'h3B_64_0A);
    send_pixel(24'h50_28_1A);
    send_pixel(24'h3C_28_19);
    check_status("thresh");
    for (int c = 1; c < 4; c++) rd_chk(0, c, "thresh");

    send_pixel({8'd80, 8'd100, 8'd250});
    send_pixel({8'd80, 8'd100, 8'd5});
    send_pixel({8'd80, 8'd100, 8'd100});
    check_status("wrap");
    for (int c = 4; c < 7; c++) rd_chk(0, c, "wrap");

    do_reset();
    send_partial(10);
    repeat (20) @(negedge fpga_clk);
    send_pixel(24'h50_64_0A);
    check_status("abort");
    rd_chk(0, 0, "abort");
    rd_chk(0, 1, "abort");

    do_reset();
    for (int i = 0; i < 40; i++) begin
      hp = int'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) send_partial(int'($urandom_range(1, 23)));
      send_pixel(rand_pix());
      check_status("rand");
    end
    for (int i = 0; i < exp_cnt; i++) rd_chk(i / W, i % W, "rand");

    do_reset();
    hp = 1;
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(rand_pix());
      check_status("fill");
    end
    rd_all("full");
    rd_chk(28, 0, "oor_row");
    rd_chk(0, 28, "oor_col");
    rd_chk(31, 31, "oor_both");

    for (int i = 0; i < 3; i++) send_pixel(rand_pix());
    check_status("drop3");
    rd_chk(27, 27, "drop3");
    rd_chk(0, 0, "drop3");
    for (int i = 0; i < 253; i++) send_pixel(rand_pix());
    check_status("dropsat");
    rd_chk(27, 27, "dropsat");

    clear = 1'b1;
    @(negedge fpga_clk);
    clear = 1'b0;
    model_reset();
    check_status("clear");
    rd_all("clear");

    do_reset();
    for (int i = 0; i < 4; i++) send_pixel(rand_pix());
    write_enable = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    check_status("midrst");
    rd_chk(0, 0, "midrst");
    send_pixel(24'h50_64_0A);
    check_status("postrst");
    rd_chk(0, 0, "postrst");
    rd_chk(0, 1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
